// File: rtl/cam_btn_ctrl.sv
// Purpose: sync, debounce and mode-shape N_CH camera buttons (level / toggle / one-shot) on one clock.
// Latency: btn to btn_rise = 2 sync + 1..DIV to first tick + (DEB_SAMPLES-1)*DIV + 1 cycles; btn_val one cycle later.
// Backpressure: none; inputs are raw levels and outputs are free-running strobes/levels.
module cam_btn_ctrl #(
  parameter int                  N_CH        = 3,
  parameter int                  DIV         = 1200000,
  parameter int                  DEB_SAMPLES = 3,
  parameter int                  PULSE_LEN   = 24,
  parameter logic [2*N_CH-1:0]   MODES       = 6'b011000,
  parameter logic [N_CH-1:0]     TOG_INIT    = 3'b000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_CH-1:0] btn,
  output logic [N_CH-1:0] btn_val,
  output logic [N_CH-1:0] btn_rise,
  output logic            tick
);

  localparam int PW  = (DIV > 1)         ? $clog2(DIV)         : 1;
  localparam int CW  = (DEB_SAMPLES > 1) ? $clog2(DEB_SAMPLES) : 1;
  localparam int PLW = (PULSE_LEN > 1)   ? $clog2(PULSE_LEN)   : 1;

  localparam logic [PW-1:0]  DIV_LAST   = PW'(DIV - 1);
  localparam logic [CW-1:0]  DEB_LAST   = CW'(DEB_SAMPLES - 1);
  localparam logic [PLW-1:0] PULSE_LAST = PLW'(PULSE_LEN - 1);

  localparam logic [1:0] MODE_TOGGLE  = 2'b01;
  localparam logic [1:0] MODE_ONESHOT = 2'b10;

  if (N_CH < 1 || DIV < 1 || DEB_SAMPLES < 1 || PULSE_LEN < 1) begin : g_param_err
    $error("cam_btn_ctrl: N_CH, DIV, DEB_SAMPLES and PULSE_LEN must all be >= 1");
  end

  logic [PW-1:0]   pre_cnt;
  logic [PW-1:0]   pre_nxt;
  logic [N_CH-1:0] sync_q1;
  logic [N_CH-1:0] sync_q2;
  logic [N_CH-1:0] deb;
  logic [N_CH-1:0] deb_d;

  assign pre_nxt = (pre_cnt == DIV_LAST) ? '0 : pre_cnt + 1'b1;

  // Free-running prescaler; tick is registered from the next count so it is low in reset even for DIV=1.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pre_cnt <= '0;
      tick    <= 1'b0;
    end else begin
      pre_cnt <= pre_nxt;
      tick    <= (pre_nxt == DIV_LAST);
    end
  end

  // Two-flop synchroniser for the asynchronous button inputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= btn;
      sync_q2 <= sync_q1;
    end
  end

  // One-cycle delayed debounced level for edge detection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      deb_d <= '0;
    end else begin
      deb_d <= deb;
    end
  end

  assign btn_rise = deb & ~deb_d;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    localparam logic [1:0] MODE = MODES[2*i +: 2];

    logic [CW-1:0] deb_cnt;
    logic          deb_q;
    logic          val_q;

    // Accept a new level only after DEB_SAMPLES consecutive differing ticks; an agreeing tick restarts the count.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        deb_cnt <= '0;
        deb_q   <= 1'b0;
      end else if (tick) begin
        if (sync_q2[i] == deb_q) begin
          deb_cnt <= '0;
        end else if (deb_cnt == DEB_LAST) begin
          deb_q   <= sync_q2[i];
          deb_cnt <= '0;
        end else begin
          deb_cnt <= deb_cnt + 1'b1;
        end
      end
    end

    assign deb[i] = deb_q;

    if (MODE == MODE_TOGGLE) begin : g_toggle
      // Flip the latched output once per accepted press.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          val_q <= TOG_INIT[i];
        end else if (btn_rise[i]) begin
          val_q <= ~val_q;
        end
      end
    end else if (MODE == MODE_ONESHOT) begin : g_oneshot
      logic [PLW-1:0] pcnt;

      // Fixed-width pulse; presses during an active pulse are ignored.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          val_q <= 1'b0;
          pcnt  <= '0;
        end else if (val_q) begin
          if (pcnt == '0) begin
            val_q <= 1'b0;
          end else begin
            pcnt <= pcnt - 1'b1;
          end
        end else if (btn_rise[i]) begin
          val_q <= 1'b1;
          pcnt  <= PULSE_LAST;
        end
      end
    end else begin : g_level
      // Loading deb (deb_d's next value) keeps level outputs aligned with the other modes: one cycle after btn_rise.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          val_q <= 1'b0;
        end else begin
          val_q <= deb_q;
        end
      end
    end

    assign btn_val[i] = val_q;
  end

endmodule

// File: tb/tb_cam_btn_ctrl.sv
// Purpose: directed self-checking bench for cam_btn_ctrl (level, glitch, toggle, one-shot, reset, simultaneous).
// Latency: expected edges are derived from the tick phase, counted in clock edges since reset release.
// Backpressure: not applicable.
module tb_cam_btn_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [2:0] btn = '0;
  logic [2:0] btn40 = '0;
  logic [2:0] btn_val, btn_rise;
  logic [2:0] val40, rise40;
  logic       tick, tick40;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always #5 clk = ~clk;

  cam_btn_ctrl #(
    .N_CH(3), .DIV(4), .DEB_SAMPLES(3), .PULSE_LEN(5),
    .MODES(6'b011000), .TOG_INIT(3'b100)
  ) u_dut (
    .clk(clk), .reset(rst_n), .btn(btn),
    .btn_val(btn_val), .btn_rise(btn_rise), .tick(tick)
  );

  cam_btn_ctrl #(
    .N_CH(3), .DIV(4), .DEB_SAMPLES(3), .PULSE_LEN(40),
    .MODES(6'b011000), .TOG_INIT(3'b100)
  ) u_dut40 (
    .clk(clk), .reset(rst_n), .btn(btn40),
    .btn_val(val40), .btn_rise(rise40), .tick(tick40)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clock; sample point is 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  // Edge (counted from reset release) after which btn_rise is seen for a change driven just after edge n:
  // sync visible to edge n+3, first tick-evaluating edge is the next multiple of 4, then two more ticks.
  function automatic int exp_rise(input int n);
    return ((n + 6) / 4) * 4 + 8;
  endfunction

  task automatic wait_rise(input int ch, input int budget, output int e);
    e = -1;
    for (int k = 0; k < budget && e < 0; k++) begin
      step();
      if (btn_rise[ch]) e = cyc;
    end
  endtask

  initial begin
    int n, m, e, fe, cnt, first, high, rises, second;

    // Reset state
    #1 rst_n = 1'b0;
    #2;
    chk("rst_val", int'(btn_val), 4);
    chk("rst_rise", int'(btn_rise), 0);
    chk("rst_tick", int'(tick), 0);
    chk("rst_val40", int'(val40), 4);
    @(posedge clk);
    #1 rst_n = 1'b1;
    cyc = 0;

    // Tick phase: high in the cycle after edge 3, low after edge 4
    steps(3);
    chk("tick_hi", int'(tick), 1);
    step();
    chk("tick_lo", int'(tick), 0);

    // 1: level channel 0, press then release
    n = cyc;
    btn[0] = 1'b1;
    wait_rise(0, 30, e);
    chk("lvl_rise_edge", e, exp_rise(n));
    chk("lvl_val_at_rise", int'(btn_val[0]), 0);
    step();
    chk("lvl_rise_width", int'(btn_rise[0]), 0);
    chk("lvl_val_after", int'(btn_val[0]), 1);
    steps(10);
    m = cyc;
    btn[0] = 1'b0;
    fe = -1;
    rises = 0;
    for (int k = 0; k < 30 && fe < 0; k++) begin
      step();
      if (btn_rise[0]) rises++;
      if (!btn_val[0]) fe = cyc;
    end
    chk("lvl_fall_edge", fe, exp_rise(m) + 1);
    chk("lvl_fall_norise", rises, 0);
    steps(5);

    // 2: glitch of 6 cycles spans at most two ticks
    btn[0] = 1'b1;
    steps(6);
    btn[0] = 1'b0;
    cnt = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (btn_rise[0] || btn_val[0]) cnt++;
    end
    chk("glitch_ignored", cnt, 0);

    // 3: toggle channel 2
    chk("tog_init", int'(btn_val[2]), 1);
    n = cyc;
    btn[2] = 1'b1;
    wait_rise(2, 30, e);
    chk("tog_rise_edge", e, exp_rise(n));
    chk("tog_val_at_rise", int'(btn_val[2]), 1);
    step();
    chk("tog_flip1", int'(btn_val[2]), 0);
    cnt = 0;
    for (int k = 0; k < 200; k++) begin
      step();
      if (btn_rise[2]) cnt++;
    end
    chk("tog_hold_rises", cnt, 0);
    chk("tog_hold_val", int'(btn_val[2]), 0);
    btn[2] = 1'b0;
    steps(30);
    btn[2] = 1'b1;
    wait_rise(2, 30, e);
    chk("tog_rise2_seen", int'(e > 0), 1);
    step();
    chk("tog_flip2", int'(btn_val[2]), 1);
    btn[2] = 1'b0;
    steps(30);

    // 4: one-shot channel 1, PULSE_LEN=5 with a long hold
    n = cyc;
    btn[1] = 1'b1;
    wait_rise(1, 30, e);
    chk("os_rise_edge", e, exp_rise(n));
    high = 0;
    first = -1;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (btn_val[1]) begin
        high++;
        if (first < 0) first = k;
      end
    end
    chk("os_start", first, 1);
    chk("os_width", high, 5);
    steps(80);
    btn[1] = 1'b0;
    steps(30);

    // 4b: PULSE_LEN=40 instance with a second press during the pulse
    n = cyc;
    btn40[1] = 1'b1;
    e = -1;
    for (int k = 0; k < 30 && e < 0; k++) begin
      step();
      if (rise40[1]) e = cyc;
    end
    chk("os40_rise_edge", e, exp_rise(n));
    high = 0;
    rises = 0;
    second = -1;
    for (int k = 1; k <= 100; k++) begin
      if (k == 1)  btn40[1] = 1'b0;
      if (k == 17) btn40[1] = 1'b1;
      if (k == 61) btn40[1] = 1'b0;
      step();
      if (val40[1]) high++;
      if (rise40[1]) begin
        rises++;
        second = k;
      end
    end
    chk("os40_width", high, 40);
    chk("os40_second_press", rises, 1);
    chk("os40_second_mid", int'(second > 0 && second < 40), 1);
    steps(30);

    // 5: reset during ch1 pulse while ch0 debounce count is 2
    btn[1] = 1'b1;
    steps(4);
    btn[0] = 1'b1;
    wait_rise(1, 30, e);
    steps(2);
    chk("rst5_pulse_active", int'(btn_val[1]), 1);
    rst_n = 1'b0;
    #1;
    chk("rst5_val", int'(btn_val), 4);
    chk("rst5_tick", int'(tick), 0);
    chk("rst5_rise", int'(btn_rise), 0);
    btn[1] = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    cyc = 0;
    step();
    chk("rst5_val_post", int'(btn_val), 4);
    cyc = 1;
    e = -1;
    for (int k = 0; k < 30 && e < 0; k++) begin
      step();
      if (btn_rise[0]) e = cyc;
    end
    chk("rst5_rise_edge", e, 12);
    cnt = 0;
    for (int k = 0; k < 30; k++) begin
      step();
      if (btn_rise[0]) cnt++;
    end
    chk("rst5_single_rise", cnt, 0);

    // 6: all three channels pressed in the same cycle
    btn[0] = 1'b0;
    steps(30);
    btn = 3'b111;
    wait_rise(0, 30, e);
    chk("sim_rise", int'(btn_rise), 7);
    step();
    chk("sim_val", int'(btn_val), 3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
